// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper phase sequencer.
// Phase table, FSM state encoding and default widths live here.
package stepper_pkg;

    localparam int DIV_W_DEF = 26;
    localparam int CNT_W_DEF = 16;
    localparam int POS_W_DEF = 24;

    // Entry i is the coil pattern for idx i; odd entries are the full-step positions.
    localparam logic [7:0][3:0] PHASE_TABLE = {
        4'b1001, 4'b1000, 4'b1100, 4'b0100,
        4'b0110, 4'b0010, 4'b0011, 4'b0001
    };

    localparam logic [2:0] IDX_RESET = 3'd1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Full mode from an even idx takes a single aligning step to reach a full-step position.
    function automatic logic [1:0] step_delta(input logic [2:0] idx, input logic half);
        return (!half && idx[0]) ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/stepper_if.sv
// Command/status bundle between the motion-control FSM and the stepper sequencer.
// The master modport is the motion controller; the slave modport is the sequencer.
interface stepper_if
    import stepper_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int POS_W = POS_W_DEF
);
    logic             start;
    logic [CNT_W-1:0] steps;
    logic             dir;
    logic             half;
    logic [DIV_W-1:0] period;
    logic             hold_en;
    logic             abort;
    logic [3:0]       coil;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             step_pulse;
    logic [POS_W-1:0] pos;

    modport master (
        output start, steps, dir, half, period, hold_en, abort,
        input  coil, busy, done, aborted, step_pulse, pos
    );

    modport slave (
        input  start, steps, dir, half, period, hold_en, abort,
        output coil, busy, done, aborted, step_pulse, pos
    );

endinterface

// File: rtl/step_prescaler.sv
// Period counter: counts 0..period-1 while enabled and flags the terminal count.
// period must be at least 1; clr has priority over counting.
module step_prescaler #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         areset_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] period,
    output logic         tick
);

    logic [W-1:0] cnt;

    assign tick = en && !clr && (cnt == period - W'(1));

    always_ff @(posedge clk) begin
        if (!areset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/stepper_seq.sv
// 4-coil stepper phase sequencer: runs N-step moves in full or half-step mode,
// tracks signed position in half-step units and drives registered coil outputs.
//
//   state | meaning
//   IDLE  | no move; coils hold table[idx] or off per hold_en; waits for start
//   RUN   | move active; steps on each prescaler tick until remaining hits 0 or abort
module stepper_seq
    import stepper_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int POS_W = POS_W_DEF
) (
    input  logic clk,
    input  logic areset_n,
    stepper_if.slave bus
);

    state_t           state, state_n;
    logic [2:0]       idx, idx_n;
    logic [POS_W-1:0] pos, pos_n;
    logic [CNT_W-1:0] remaining, remaining_n;
    logic             dir_q, dir_n;
    logic             half_q, half_n;
    logic [DIV_W-1:0] period_q, period_n;
    logic             busy, busy_n;
    logic             done, done_n;
    logic             aborted, aborted_n;
    logic             pulse, pulse_n;
    logic [3:0]       coil, coil_n;
    logic             presc_clr;
    logic             presc_en;
    logic             tick;
    logic [1:0]       delta;

    // After the final step the FSM spends one cycle in RUN to raise done; no ticks then.
    assign presc_en = (state == RUN) && (remaining != '0);
    assign delta    = step_delta(idx, half_q);

    step_prescaler #(.W(DIV_W)) u_presc (
        .clk      (clk),
        .areset_n (areset_n),
        .clr      (presc_clr),
        .en       (presc_en),
        .period   (period_q),
        .tick     (tick)
    );

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        pos_n       = pos;
        remaining_n = remaining;
        dir_n       = dir_q;
        half_n      = half_q;
        period_n    = period_q;
        busy_n      = busy;
        done_n      = 1'b0;
        aborted_n   = aborted;
        pulse_n     = 1'b0;
        presc_clr   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    dir_n       = bus.dir;
                    half_n      = bus.half;
                    period_n    = (bus.period == '0) ? DIV_W'(1) : bus.period;
                    remaining_n = bus.steps;
                    presc_clr   = 1'b1;
                    aborted_n   = 1'b0;
                    if (bus.steps == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = RUN;
                        busy_n  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (tick) begin
                    idx_n       = dir_q ? idx + {1'b0, delta} : idx - {1'b0, delta};
                    pos_n       = dir_q ? pos + POS_W'(delta) : pos - POS_W'(delta);
                    remaining_n = remaining - CNT_W'(1);
                    pulse_n     = 1'b1;
                end
                if (remaining == '0) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else if (bus.abort) begin
                    state_n   = IDLE;
                    busy_n    = 1'b0;
                    done_n    = 1'b1;
                    aborted_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase

        coil_n = (busy_n || bus.hold_en) ? PHASE_TABLE[idx_n] : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (!areset_n) begin
            state     <= IDLE;
            idx       <= IDX_RESET;
            pos       <= '0;
            remaining <= '0;
            dir_q     <= 1'b0;
            half_q    <= 1'b0;
            period_q  <= DIV_W'(1);
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            pulse     <= 1'b0;
            coil      <= bus.hold_en ? PHASE_TABLE[IDX_RESET] : 4'b0000;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            pos       <= pos_n;
            remaining <= remaining_n;
            dir_q     <= dir_n;
            half_q    <= half_n;
            period_q  <= period_n;
            busy      <= busy_n;
            done      <= done_n;
            aborted   <= aborted_n;
            pulse     <= pulse_n;
            coil      <= coil_n;
        end
    end

    assign bus.coil       = coil;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.aborted    = aborted;
    assign bus.step_pulse = pulse;
    assign bus.pos        = pos;

endmodule

// File: tb/tb_stepper_seq.sv
// Directed bench for stepper_seq: an event-schedule model checked every cycle,
// plus literal expectations for the scenarios of the move test plan.
module tb_stepper_seq;

    localparam int DIV_W = 26;
    localparam int CNT_W = 16;
    localparam int POS_W = 24;

    logic clk = 1'b0;
    logic areset_n = 1'b0;
    always #5 clk = ~clk;

    stepper_if #(.DIV_W(DIV_W), .CNT_W(CNT_W), .POS_W(POS_W)) bus ();

    stepper_seq #(.DIV_W(DIV_W), .CNT_W(CNT_W), .POS_W(POS_W)) dut (
        .clk      (clk),
        .areset_n (areset_n),
        .bus      (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [3:0] tab [8];

    // Model: a move accepted at edge t0 with period P steps at edges t0+P, t0+2P, ...
    int               cyc = 0;
    logic [2:0]       m_idx;
    logic [POS_W-1:0] m_pos;
    bit               m_busy, m_done, m_ab, m_pulse;
    logic [3:0]       m_coil;
    int               m_n, m_p, m_cnt, m_t0;
    bit               m_dir, m_half;

    logic [3:0] pulse_coils [$];
    int         pulse_cycs [$];
    int         done_cyc;
    int         acc_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        int  delta;
        bit  fin;
        cyc++;
        m_done  = 1'b0;
        m_pulse = 1'b0;
        if (!areset_n) begin
            m_idx  = 3'd1;
            m_pos  = '0;
            m_busy = 1'b0;
            m_ab   = 1'b0;
        end else if (m_busy) begin
            fin = (m_cnt == m_n);
            if (!fin && ((cyc - m_t0) % m_p == 0)) begin
                delta   = (!m_half && m_idx[0]) ? 2 : 1;
                m_idx   = 3'((int'(m_idx) + (m_dir ? delta : 8 - delta)) % 8);
                m_pos   = m_dir ? m_pos + POS_W'(delta) : m_pos - POS_W'(delta);
                m_cnt++;
                m_pulse = 1'b1;
            end
            if (fin || bus.abort) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_ab   = !fin;
            end
        end else if (bus.start) begin
            m_n    = int'(bus.steps);
            m_p    = (bus.period == '0) ? 1 : int'(bus.period);
            m_dir  = bus.dir;
            m_half = bus.half;
            m_cnt  = 0;
            m_t0   = cyc;
            m_ab   = 1'b0;
            if (m_n == 0) m_done = 1'b1;
            else          m_busy = 1'b1;
        end
        m_coil = (m_busy || bus.hold_en) ? tab[m_idx] : 4'b0000;
    endtask

    // The single compare point: every clock, model advance then DUT-vs-model check.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("coil",       32'(bus.coil),       32'(m_coil));
        chk("busy",       32'(bus.busy),       32'(m_busy));
        chk("done",       32'(bus.done),       32'(m_done));
        chk("aborted",    32'(bus.aborted),    32'(m_ab));
        chk("step_pulse", 32'(bus.step_pulse), 32'(m_pulse));
        chk("pos",        32'(bus.pos),        32'(m_pos));
        if (bus.step_pulse) begin
            pulse_coils.push_back(bus.coil);
            pulse_cycs.push_back(cyc);
        end
        if (bus.done) done_cyc = cyc;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_log();
        pulse_coils.delete();
        pulse_cycs.delete();
        done_cyc = -1;
    endtask

    task automatic start_move(input int steps, input bit dir, input bit half, input int period);
        bus.start  = 1'b1;
        bus.steps  = CNT_W'(steps);
        bus.dir    = dir;
        bus.half   = half;
        bus.period = DIV_W'(period);
        cycle();
        acc_cyc   = cyc;
        bus.start = 1'b0;
    endtask

    task automatic do_reset();
        areset_n = 1'b0;
        cycle();
        areset_n = 1'b1;
    endtask

    initial begin
        tab[0] = 4'b0001; tab[1] = 4'b0011; tab[2] = 4'b0010; tab[3] = 4'b0110;
        tab[4] = 4'b0100; tab[5] = 4'b1100; tab[6] = 4'b1000; tab[7] = 4'b1001;
        bus.start = 1'b0; bus.steps = '0; bus.dir = 1'b0; bus.half = 1'b0;
        bus.period = '0;  bus.hold_en = 1'b1; bus.abort = 1'b0;
        m_idx = 3'd1; m_pos = '0; m_busy = 1'b0; m_ab = 1'b0; m_n = 0; m_p = 1;
        m_cnt = 0; m_t0 = 0; m_dir = 1'b0; m_half = 1'b0; m_coil = 4'b0011;
        clear_log();

        areset_n = 1'b0;
        run(2);
        areset_n = 1'b1;
        cycle();
        chk("reset_coil", 32'(bus.coil), 32'h3);
        chk("reset_pos",  32'(bus.pos),  32'h0);
        chk("reset_busy", 32'(bus.busy), 32'h0);

        // full-step forward, period 3
        clear_log();
        start_move(4, 1'b1, 1'b0, 3);
        run(16);
        chk("full_fwd_npulses", 32'(pulse_coils.size()), 32'd4);
        if (pulse_coils.size() >= 4) begin
            chk("full_fwd_coil0", 32'(pulse_coils[0]), 32'h6);
            chk("full_fwd_coil1", 32'(pulse_coils[1]), 32'hC);
            chk("full_fwd_coil2", 32'(pulse_coils[2]), 32'h9);
            chk("full_fwd_coil3", 32'(pulse_coils[3]), 32'h3);
            chk("full_fwd_first_step_time", 32'(pulse_cycs[0] - acc_cyc), 32'd3);
            chk("full_fwd_last_step_time",  32'(pulse_cycs[3] - acc_cyc), 32'd12);
            chk("full_fwd_done_time",       32'(done_cyc - pulse_cycs[3]), 32'd1);
        end
        chk("full_fwd_pos", 32'(bus.pos), 32'd8);

        // half-step reverse, period 1, from idx 1
        do_reset();
        clear_log();
        start_move(3, 1'b0, 1'b1, 1);
        run(6);
        chk("half_rev_npulses", 32'(pulse_coils.size()), 32'd3);
        if (pulse_coils.size() >= 3) begin
            chk("half_rev_coil0", 32'(pulse_coils[0]), 32'h1);
            chk("half_rev_coil1", 32'(pulse_coils[1]), 32'h9);
            chk("half_rev_coil2", 32'(pulse_coils[2]), 32'h8);
            chk("half_rev_consecutive", 32'(pulse_cycs[2] - pulse_cycs[0]), 32'd2);
        end
        chk("half_rev_pos", 32'(bus.pos), 32'h00FF_FFFD);

        // half move to idx 2, then full move aligns on its first step
        do_reset();
        start_move(1, 1'b1, 1'b1, 1);
        run(4);
        chk("align_pre_coil", 32'(bus.coil), 32'h2);
        clear_log();
        start_move(2, 1'b1, 1'b0, 1);
        run(5);
        chk("align_npulses", 32'(pulse_coils.size()), 32'd2);
        if (pulse_coils.size() >= 2) begin
            chk("align_coil0", 32'(pulse_coils[0]), 32'h6);
            chk("align_coil1", 32'(pulse_coils[1]), 32'hC);
        end
        chk("align_pos", 32'(bus.pos), 32'd4);

        // long move: ignored start mid-move, then abort after the 5th step
        do_reset();
        clear_log();
        start_move(100, 1'b1, 1'b0, 2);
        for (int i = 0; i < 20 && pulse_coils.size() < 2; i++) cycle();
        start_move(5, 1'b0, 1'b1, 7);
        for (int i = 0; i < 40 && pulse_coils.size() < 5; i++) cycle();
        chk("abort_reached_5th_step", 32'(pulse_coils.size()), 32'd5);
        bus.abort = 1'b1;
        cycle();
        bus.abort = 1'b0;
        chk("abort_done",    32'(bus.done),    32'h1);
        chk("abort_aborted", 32'(bus.aborted), 32'h1);
        chk("abort_pos",     32'(bus.pos),     32'd10);
        run(6);
        chk("abort_pos_frozen",   32'(bus.pos),  32'd10);
        chk("abort_busy_stays_0", 32'(bus.busy), 32'h0);

        // steps=0: done next cycle, busy never rises, aborted cleared
        clear_log();
        start_move(0, 1'b1, 1'b0, 5);
        chk("zero_done",    32'(bus.done),    32'h1);
        chk("zero_busy",    32'(bus.busy),    32'h0);
        chk("zero_aborted", 32'(bus.aborted), 32'h0);
        run(2);

        // period=0 behaves as period=1
        clear_log();
        start_move(2, 1'b0, 1'b1, 0);
        run(4);
        chk("p0_npulses", 32'(pulse_coils.size()), 32'd2);
        if (pulse_coils.size() >= 2) begin
            chk("p0_first_time",  32'(pulse_cycs[0] - acc_cyc), 32'd1);
            chk("p0_second_time", 32'(pulse_cycs[1] - acc_cyc), 32'd2);
        end

        // hold_en=0: coils off when idle, on while busy
        bus.hold_en = 1'b0;
        cycle();
        chk("nohold_idle_coil", 32'(bus.coil), 32'h0);
        start_move(3, 1'b1, 1'b1, 2);
        run(10);
        bus.hold_en = 1'b1;
        run(2);

        // reset mid-move discards the move
        clear_log();
        start_move(50, 1'b1, 1'b0, 2);
        run(9);
        areset_n = 1'b0;
        cycle();
        chk("midreset_busy", 32'(bus.busy), 32'h0);
        chk("midreset_pos",  32'(bus.pos),  32'h0);
        chk("midreset_done", 32'(bus.done), 32'h0);
        areset_n = 1'b1;
        run(5);
        chk("midreset_no_done", 32'(done_cyc), 32'hFFFF_FFFF);

        // ignored abort in idle
        bus.abort = 1'b1;
        run(2);
        bus.abort = 1'b0;
        run(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stepper_seq.md
Name: stepper_seq

Overview:
Parametrised 4-coil stepper-motor phase sequencer and the successor to the fixed full-step ramp sequencer.
- Runs a commanded move of N steps: programmable step period, direction, full/half-step mode, coil hold and abort.
- Reports a signed position and a start/busy/done handshake.
- Sits between the motion-control FSM and the coil driver pins.

Parameters:
DIV_W, 26, width of step-period prescaler and period input
CNT_W, 16, width of step-count request and remaining counter
POS_W, 24, width of signed position counter (half-step units)

Ports:
clk  in  1  system clock
areset_n  in  1  synchronous active-low reset
start  in  1  one-cycle move request, accepted only when busy=0
steps  in  CNT_W  number of steps to move, latched on accepted start
dir  in  1  1=forward (index +), 0=reverse, latched on start
half  in  1  1=half-step, 0=full-step, latched on start
period  in  DIV_W  clocks per step, latched on start; 0 treated as 1
hold_en  in  1  1=energise table[idx] when idle; 0=coils off when idle (live, not latched)
abort  in  1  stop the move after the current cycle
coil  out  4  coil drive pattern
busy  out  1  move in progress
done  out  1  one-cycle pulse at move end (normal or aborted)
aborted  out  1  set with done if move ended by abort; cleared on next accepted start
step_pulse  out  1  one-cycle pulse on every applied step
pos  out  POS_W  signed position, half-step units

Behaviour:
- Reset is synchronous, sampled on rising clk while areset_n=0. Reset values:
  - idx=1, pos=0, busy=0, done=0, aborted=0, step_pulse=0, prescaler=0.
  - coil=0 while hold_en=0, else 4'b0011.
- Phase table, idx 0..7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001.
  - Odd indices have two coils on and are the full-step positions.
- State machine IDLE, RUN:
  - IDLE with start=1: latch steps/dir/half/period (period 0 -> 1), clear prescaler and aborted.
    - steps=0: stay IDLE; done=1 on the next cycle; coil, idx and pos unchanged.
    - steps>0: busy=1 on the next cycle, state RUN.
  - start while busy=1: ignored, no latch.
- RUN:
  - Prescaler counts 0..period-1.
  - When the prescaler reaches period-1: tick, prescaler returns to 0.
  - First step occurs `period` cycles after busy rises.
- On a tick:
  - Half mode: idx += ±1 mod 8; pos += ±1.
  - Full mode with idx odd: idx += ±2 mod 8; pos += ±2.
  - Full mode with idx even (left by a prior half move): idx += ±1 (aligning step); pos += ±1; counts as one step.
  - step_pulse=1 and the remaining count decrements, all in the same cycle as the coil update.
- Tick with remaining=1: final step applied; next cycle busy=0 and done=1 (one cycle), state IDLE.
- abort=1 in RUN: no further tick. Next cycle busy=0, done=1, aborted=1, state IDLE; idx and pos keep their last values.
  - If abort coincides with a tick, that tick's step is still applied.
- abort in IDLE has no effect.
- coil:
  - While busy: always table[idx].
  - While idle: table[idx] if hold_en=1, else 0.
  - Registered; no combinational path from inputs.
- pos wraps as two's complement; no saturation.
- idx wraps 7<->0 in both directions.
- areset_n=0 mid-move: immediate return to reset values. No done pulse; the move is discarded.

Decomposition:
- Shared package stepper_pkg holds:
  - the 8-entry phase table constant;
  - the state enum (IDLE, RUN);
  - the default widths.
- One sub-module, step_prescaler: a period counter with load/clear and a tick output, reusable by other timed blocks.
- The FSM, index, position and handshake logic stay in stepper_seq.

Test Plan:
- Full, forward: reset, hold_en=1, start steps=4 dir=1 half=0 period=3. Expect:
  - coil 0011 -> 0110 -> 1100 -> 1001 -> 0011, a step every 3 clocks;
  - 4 step_pulses, pos=8;
  - done one cycle after the 4th step, busy low.
- Half, reverse: from idx=1, steps=3 dir=0 half=1 period=1. Expect coil 0001, 1001, 1000 on consecutive cycles; pos=-3.
- Mode switch alignment: half move leaves idx=2 (coil 0010); then full steps=2 dir=1. Expect coil 0110 (aligning), then 1100; pos +3 total.
- Abort and ignored start: steps=100 period=2.
  - Assert abort after the 5th step_pulse: done and aborted pulse next cycle; pos=10 frozen.
  - A start while busy earlier in the move changes nothing.
- Edge cases:
  - steps=0: done one cycle later, busy never rises.
  - period=0: behaves as period=1.
  - hold_en=0 when idle: coil=0.
  - areset_n=0 mid-move: busy=0, pos=0, no done.
